// File: rtl/pattern_det_sched_if.sv
// rtl/pattern_det_sched_if.sv - per-channel frame request and serial bit stream bundle
//
// Carries the N_CH requester streams into the pattern-detect scheduler.
//   req      requester -> scheduler   per-channel frame request (level)
//   in_bit   requester -> scheduler   per-channel serial data bit
//   in_valid requester -> scheduler   per-channel bit valid
//   in_last  requester -> scheduler   last bit of the frame
//   in_ready scheduler -> requester   bit accepted when in_valid & in_ready
//   gnt      scheduler -> requester   one-hot registered grant
// master = stream sources, slave = scheduler.
interface pattern_det_sched_if #(
    parameter int N_CH = 4
);
    logic [N_CH-1:0] req;
    logic [N_CH-1:0] in_bit;
    logic [N_CH-1:0] in_valid;
    logic [N_CH-1:0] in_last;
    logic [N_CH-1:0] in_ready;
    logic [N_CH-1:0] gnt;

    modport master (
        output req, in_bit, in_valid, in_last,
        input  in_ready, gnt
    );

    modport slave (
        input  req, in_bit, in_valid, in_last,
        output in_ready, gnt
    );
endinterface

// File: rtl/pattern_det_sched.sv
// rtl/pattern_det_sched.sv - round-robin frame scheduler sharing one serial pattern matcher
//
// Grants one requesting channel at a time for a whole frame, runs its bits through a
// PLEN-bit matcher whose history is cleared between frames, and keeps a saturating
// match counter per channel.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   bus             stream bundle (req/in_bit/in_valid/in_last in, in_ready/gnt out)
//   o_busy          high while a frame is streaming or closing
//   o_match         one-cycle pulse when the pattern completes
//   o_match_ch      channel of the latest match (holds between matches)
//   o_timeout_err   one-cycle pulse when a frame is aborted for inactivity
//   i_clr_cnt       synchronous clear of all match counters
//   i_cnt_sel       counter read select
//   o_cnt_data      combinational read of the selected counter
module pattern_det_sched #(
    parameter int              N_CH    = 4,
    parameter int              PLEN    = 5,
    parameter logic [PLEN-1:0] PATTERN = 5'b00101,
    parameter int              TIMEOUT = 16,
    parameter int              CNT_W   = 16,
    localparam int             CW      = $clog2(N_CH)
) (
    input  logic                clk,
    input  logic                rst_n,
    pattern_det_sched_if.slave  bus,
    output logic                o_busy,
    output logic                o_match,
    output logic [CW-1:0]       o_match_ch,
    output logic                o_timeout_err,
    input  logic                i_clr_cnt,
    input  logic [CW-1:0]       i_cnt_sel,
    output logic [CNT_W-1:0]    o_cnt_data
);

    localparam int FW = $clog2(PLEN + 1);
    localparam int IW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [N_CH-1:0]    r_gnt, w_gnt_nxt;
    logic [CW-1:0]      r_idx, w_idx_nxt;
    logic [CW-1:0]      r_rr_ptr, w_rr_nxt;
    // Only PLEN-1 bits of history are needed: the incoming bit completes the window.
    logic [PLEN-2:0]    r_hist, w_hist_nxt;
    logic [FW-1:0]      r_fill, w_fill_nxt;
    logic [IW-1:0]      r_idle, w_idle_nxt;
    logic               r_match, w_match_nxt;
    logic [CW-1:0]      r_match_ch, w_match_ch_nxt;
    logic               r_timeout_err, w_tmo_nxt;
    logic [CNT_W-1:0]   r_cnt [N_CH];

    logic               w_acc;
    logic               w_bit;
    logic               w_last;
    logic [PLEN-1:0]    w_shift;
    logic [CW-1:0]      w_idx_inc;
    logic               w_pick_vld;
    logic [CW-1:0]      w_pick_idx;
    logic [CW-1:0]      w_scan;

    assign w_acc     = (r_state == S_STREAM) && bus.in_valid[r_idx];
    assign w_bit     = bus.in_bit[r_idx];
    assign w_last    = bus.in_last[r_idx];
    assign w_shift   = {r_hist, w_bit};
    assign w_idx_inc = (r_idx == CW'(N_CH - 1)) ? '0 : r_idx + CW'(1);

    // Round-robin pick: scan offsets from the far end down so the requester closest
    // to (at or after) r_rr_ptr is the one left standing.
    always_comb begin
        w_pick_vld = 1'b0;
        w_pick_idx = '0;
        w_scan     = '0;
        for (int k = N_CH - 1; k >= 0; k--) begin
            w_scan = CW'((int'(r_rr_ptr) + k) % N_CH);
            if (bus.req[w_scan]) begin
                w_pick_vld = 1'b1;
                w_pick_idx = w_scan;
            end
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_gnt_nxt      = r_gnt;
        w_idx_nxt      = r_idx;
        w_rr_nxt       = r_rr_ptr;
        w_hist_nxt     = r_hist;
        w_fill_nxt     = r_fill;
        w_idle_nxt     = r_idle;
        w_match_nxt    = 1'b0;
        w_match_ch_nxt = r_match_ch;
        w_tmo_nxt      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_pick_vld) begin
                    w_gnt_nxt   = N_CH'(1) << w_pick_idx;
                    w_idx_nxt   = w_pick_idx;
                    w_state_nxt = S_STREAM;
                end
            end
            S_STREAM: begin
                if (w_acc) begin
                    w_hist_nxt = w_shift[PLEN-2:0];
                    w_idle_nxt = '0;
                    if (r_fill != FW'(PLEN)) begin
                        w_fill_nxt = r_fill + FW'(1);
                    end
                    // fill_before >= PLEN-1 means this bit completes a full window
                    // made only of bits from the current frame.
                    if ((w_shift == PATTERN) && (r_fill >= FW'(PLEN - 1))) begin
                        w_match_nxt    = 1'b1;
                        w_match_ch_nxt = r_idx;
                    end
                    if (w_last) begin
                        w_rr_nxt    = w_idx_inc;
                        w_gnt_nxt   = '0;
                        w_state_nxt = S_DONE;
                    end
                end else if (r_idle == IW'(TIMEOUT - 1)) begin
                    // This cycle is the TIMEOUT-th consecutive one without a bit.
                    w_tmo_nxt   = 1'b1;
                    w_rr_nxt    = w_idx_inc;
                    w_gnt_nxt   = '0;
                    w_state_nxt = S_DONE;
                end else begin
                    w_idle_nxt = r_idle + IW'(1);
                end
            end
            S_DONE: begin
                w_hist_nxt  = '0;
                w_fill_nxt  = '0;
                w_idle_nxt  = '0;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_gnt_nxt   = '0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_gnt         <= '0;
            r_idx         <= '0;
            r_rr_ptr      <= '0;
            r_hist        <= '0;
            r_fill        <= '0;
            r_idle        <= '0;
            r_match       <= 1'b0;
            r_match_ch    <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_gnt         <= w_gnt_nxt;
            r_idx         <= w_idx_nxt;
            r_rr_ptr      <= w_rr_nxt;
            r_hist        <= w_hist_nxt;
            r_fill        <= w_fill_nxt;
            r_idle        <= w_idle_nxt;
            r_match       <= w_match_nxt;
            r_match_ch    <= w_match_ch_nxt;
            r_timeout_err <= w_tmo_nxt;
        end
    end

    // Counter bumps while the match pulse is visible; a coincident clear wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_CH; i++) begin
                r_cnt[i] <= '0;
            end
        end else if (i_clr_cnt) begin
            for (int i = 0; i < N_CH; i++) begin
                r_cnt[i] <= '0;
            end
        end else if (r_match && (r_cnt[r_match_ch] != {CNT_W{1'b1}})) begin
            r_cnt[r_match_ch] <= r_cnt[r_match_ch] + CNT_W'(1);
        end
    end

    assign bus.gnt       = r_gnt;
    assign bus.in_ready  = (r_state == S_STREAM) ? r_gnt : '0;
    assign o_busy        = (r_state == S_STREAM) || (r_state == S_DONE);
    assign o_match       = r_match;
    assign o_match_ch    = r_match_ch;
    assign o_timeout_err = r_timeout_err;
    assign o_cnt_data    = r_cnt[i_cnt_sel];

endmodule
